// File: rtl/dram_cmd_sequencer_if.sv
// dram_cmd_sequencer_if: request handshake and DIMM command bus of the DDR5 command sequencer
interface dram_cmd_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [35:0] req_addr;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic        cmd_channel;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        done_valid;
  logic [1:0]  done_op;
  logic        req_err;
  modport master (
    output req_valid, req_op, req_addr,
    input  req_ready, cmd_valid, cmd_type, cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col,
           done_valid, done_op, req_err
  );
  modport slave (
    input  req_valid, req_op, req_addr,
    output req_ready, cmd_valid, cmd_type, cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col,
           done_valid, done_op, req_err
  );
endinterface

// File: rtl/dram_cmd_sequencer.sv
// dram_cmd_sequencer: one-request-at-a-time DDR5 ACT/RD/WR/PRE sequencer, closed- or open-page
module dram_cmd_sequencer #(
  parameter bit OPEN_PAGE = 1'b0,
  parameter int TRCD      = 39,
  parameter int TCAS      = 40,
  parameter int TCWL      = 38,
  parameter int TBURST    = 8,
  parameter int TWR       = 30,
  parameter int TRP       = 39
) (
  input logic                 clk,
  input logic                 rst,
  dram_cmd_sequencer_if.slave bus
);
  localparam int T_RD  = TCAS + TBURST;
  localparam int T_WR  = TCWL + TBURST;
  localparam int T_A   = T_RD > T_WR + TWR ? T_RD : T_WR + TWR;
  localparam int T_B   = TRCD > TRP ? TRCD : TRP;
  localparam int T_MAX = T_A > T_B ? T_A : T_B;
  localparam int CW    = $clog2(T_MAX + 1) > 8 ? $clog2(T_MAX + 1) : 8;
  typedef enum logic [3:0] {
    IDLE, PRE_WAIT, PRE, RP_WAIT, ACT0, ACT1, RCD_WAIT, CAS0, CAS1, DATA_WAIT, CLOSE_WAIT
  } state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [32:2]   addr_q, addr_d;
  logic [1:0]    op_q, op_d;
  logic          miss_q, miss_d;
  logic [31:0]   vld_q, vld_d;
  logic [15:0]   tbl_q [32];
  logic          tbl_we, accept, wr, wait_end;
  logic [4:0]    idx;
  logic          cmd_valid_q, cmd_valid_d;
  logic [2:0]    cmd_type_q, cmd_type_d;
  logic [31:0]   fld_q, fld_d;
  logic          done_valid_q, done_valid_d;
  logic [1:0]    done_op_q, done_op_d;
  logic          req_err_q, req_err_d, req_ready_q, req_ready_d;
  logic          unused;
  assign unused   = ^{bus.req_addr[35:33], bus.req_addr[1:0]};
  assign accept   = bus.req_valid && req_ready_q;
  assign addr_d   = accept ? bus.req_addr[32:2] : addr_q;
  assign op_d     = accept ? bus.req_op : op_q;
  assign idx      = {addr_d[9:7], addr_d[11:10]};
  assign wr       = op_d == 2'd1;
  assign wait_end = cnt_q <= CW'(1);
  // In open-page IDLE the counter holds the remaining PRE hold-off of the last access
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q == '0 ? '0 : cnt_q - CW'(1);
    miss_d       = miss_q;
    vld_d        = vld_q;
    tbl_we       = 1'b0;
    done_valid_d = 1'b0;
    done_op_d    = 2'd0;
    req_err_d    = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (op_d == 2'd3) req_err_d = 1'b1;
        else if (!OPEN_PAGE || !vld_q[idx]) state_d = ACT0;
        else if (tbl_q[idx] == addr_d[32:17]) state_d = CAS0;
        else begin
          miss_d  = 1'b1;
          state_d = wait_end ? PRE : PRE_WAIT;
        end
      end
      PRE_WAIT: if (wait_end) state_d = PRE;
      PRE: begin
        vld_d[idx] = 1'b0;
        state_d    = RP_WAIT;
        cnt_d      = CW'(TRP - 1);
      end
      RP_WAIT: if (wait_end) begin
        state_d = miss_q ? ACT0 : IDLE;
        miss_d  = 1'b0;
      end
      ACT0: state_d = ACT1;
      ACT1: begin
        vld_d[idx] = 1'b1;
        tbl_we     = 1'b1;
        state_d    = RCD_WAIT;
        cnt_d      = CW'(TRCD - 1);
      end
      RCD_WAIT: if (wait_end) state_d = CAS0;
      CAS0: state_d = CAS1;
      CAS1: begin
        state_d = DATA_WAIT;
        cnt_d   = wr ? CW'(T_WR - 1) : CW'(T_RD - 1);
      end
      DATA_WAIT: if (wait_end) begin
        done_valid_d = 1'b1;
        done_op_d    = op_q;
        state_d      = OPEN_PAGE ? IDLE : wr ? CLOSE_WAIT : PRE;
        cnt_d        = wr ? CW'(TWR) : '0;
      end
      CLOSE_WAIT: if (wait_end) state_d = PRE;
      default: state_d = IDLE;
    endcase
    cmd_type_d  = state_d == ACT0 ? 3'd1 : state_d == ACT1 ? 3'd2 :
                  state_d == CAS0 ? (wr ? 3'd5 : 3'd3) : state_d == CAS1 ? (wr ? 3'd6 : 3'd4) :
                  state_d == PRE ? 3'd7 : 3'd0;
    cmd_valid_d = cmd_type_d != 3'd0;
    fld_d       = cmd_valid_d ? {addr_d[6], addr_d[9:7], addr_d[11:10], addr_d[32:17],
                                 addr_d[17:12], addr_d[5:2]} : '0;
    req_ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      op_q         <= '0;
      miss_q       <= 1'b0;
      vld_q        <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_type_q   <= '0;
      fld_q        <= '0;
      done_valid_q <= 1'b0;
      done_op_q    <= '0;
      req_err_q    <= 1'b0;
      req_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      op_q         <= op_d;
      miss_q       <= miss_d;
      vld_q        <= vld_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_type_q   <= cmd_type_d;
      fld_q        <= fld_d;
      done_valid_q <= done_valid_d;
      done_op_q    <= done_op_d;
      req_err_q    <= req_err_d;
      req_ready_q  <= req_ready_d;
    end
  always_ff @(posedge clk)
    if (tbl_we) tbl_q[idx] <= addr_d[32:17];
  assign bus.req_ready   = req_ready_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_type    = cmd_type_q;
  assign bus.cmd_channel = fld_q[31];
  assign bus.cmd_bg      = fld_q[30:28];
  assign bus.cmd_bank    = fld_q[27:26];
  assign bus.cmd_row     = fld_q[25:10];
  assign bus.cmd_col     = fld_q[9:0];
  assign bus.done_valid  = done_valid_q;
  assign bus.done_op     = done_op_q;
  assign bus.req_err     = req_err_q;
endmodule
